// File: rtl/arashi_pkg.sv
// Shared helpers for the arashi write-side arbiter slice.
package arashi_pkg;

  // Index width for an N-entry selector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/arashi_rr_arb.sv
// Round-robin arbiter: one-hot grant over req, searching upward from ptr with wrap.
module arashi_rr_arb
  import arashi_pkg::*;
#(
  parameter  int N  = 4,
  localparam int IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx
);

  logic [IW-1:0] ptr_p0;
  logic [IW-1:0] cand;
  logic          found;
  int            sum;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    sum     = 0;
    for (int i = 0; i < N; i++) begin
      sum = int'(ptr_p0) + i;
      if (sum >= N) sum = sum - N;
      cand = IW'(sum);
      if (!found && req[cand]) begin
        found        = 1'b1;
        gnt[cand]    = 1'b1;
        gnt_idx      = cand;
      end
    end
  end

  // Pointer stage: advance past the winner, hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_p0 <= '0;
    end else if (N > 1 && found) begin
      ptr_p0 <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

endmodule

// File: rtl/arashi_wr_arb.sv
// Per-thread write hold buffers, round-robin selection, and registered slot-0
// drive onto the arashi_mem write bus.
module arashi_wr_arb
  import arashi_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WIDTH  = 10,
  parameter int THREAD_NUM = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [THREAD_NUM-1:0]            req_valid,
  output logic [THREAD_NUM-1:0]            req_ready,
  input  logic [MEM_WIDTH*THREAD_NUM-1:0]  req_addr,
  input  logic [DATA_WIDTH*THREAD_NUM-1:0] req_data,
  output logic [THREAD_NUM-1:0]            wr,
  output logic [MEM_WIDTH*THREAD_NUM-1:0]  waddr,
  output logic [DATA_WIDTH*THREAD_NUM-1:0] wdata,
  output logic [31:0]                      grant_cnt
);

  localparam int IW = idx_w(THREAD_NUM);

  typedef struct packed {
    logic [MEM_WIDTH-1:0]  addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  logic [THREAD_NUM-1:0] hold_v_p0;
  logic [THREAD_NUM-1:0] gnt;
  logic [THREAD_NUM-1:0] xfer;
  logic [IW-1:0]         gnt_idx;
  wr_req_t               hold_p0 [THREAD_NUM];
  wr_req_t               sel;

  logic                  wr_p1;
  logic [MEM_WIDTH-1:0]  waddr_p1;
  logic [DATA_WIDTH-1:0] wdata_p1;
  logic [31:0]           cnt_p1;

  arashi_rr_arb #(.N(THREAD_NUM)) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (hold_v_p0),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // A granted entry frees itself this cycle, so a new request can refill it.
  assign req_ready = ~hold_v_p0 | gnt;
  assign xfer      = req_valid & req_ready;
  assign sel       = hold_p0[gnt_idx];

  // Hold stage: one buffered request per thread.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_v_p0 <= '0;
    end else begin
      hold_v_p0 <= xfer | (hold_v_p0 & ~gnt);
    end
  end

  always_ff @(posedge clk) begin
    for (int t = 0; t < THREAD_NUM; t++) begin
      if (xfer[t]) begin
        hold_p0[t] <= {req_addr[t*MEM_WIDTH +: MEM_WIDTH], req_data[t*DATA_WIDTH +: DATA_WIDTH]};
      end
    end
  end

  // Output stage: address/data hold their last value when idle; only wr drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_p1    <= 1'b0;
      waddr_p1 <= '0;
      wdata_p1 <= '0;
      cnt_p1   <= '0;
    end else begin
      wr_p1 <= |gnt;
      if (|gnt) begin
        waddr_p1 <= sel.addr;
        wdata_p1 <= sel.data;
        cnt_p1   <= cnt_p1 + 32'd1;
      end
    end
  end

  // The memory commits only slot 0; the other slots stay quiet.
  always_comb begin
    wr                     = '0;
    wr[0]                  = wr_p1;
    waddr                  = '0;
    waddr[MEM_WIDTH-1:0]   = waddr_p1;
    wdata                  = '0;
    wdata[DATA_WIDTH-1:0]  = wdata_p1;
  end

  assign grant_cnt = cnt_p1;

endmodule
